// File: rtl/spi_acl_responder_if.sv
// SPI pin bundle between an SPI master and the accelerometer responder.
// Signals: SCLK, SS (active-low), SDI, SDO and SDO_EN (SDO pad enable).
interface spi_acl_responder_if;
   logic SCLK;
   logic SS;
   logic SDI;
   logic SDO;
   logic SDO_EN;

   modport master (
      output SCLK, SS, SDI,
      input  SDO, SDO_EN
   );

   modport slave (
      input  SCLK, SS, SDI,
      output SDO, SDO_EN
   );
endinterface

// File: rtl/spi_acl_responder.sv
// SPI mode-3 slave emulating the accelerometer register map.
// Ports: CLK, RST (async low), spi (SCLK/SS/SDI in, SDO/SDO_EN out),
// X_IN/Y_IN/Z_IN samples, POWER_CTL/DATA_FORMAT regs, WR_* write
// reporting, BUSY frame indicator.
module spi_acl_responder #(
   parameter logic [7:0] DEVID_VAL   = 8'hE5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   spi_acl_responder_if.slave spi,
   input  logic [9:0] X_IN,
   input  logic [9:0] Y_IN,
   input  logic [9:0] Z_IN,
   output logic [7:0] POWER_CTL,
   output logic [7:0] DATA_FORMAT,
   output logic       WR_STROBE,
   output logic [5:0] WR_ADDR,
   output logic [7:0] WR_DATA,
   output logic       BUSY
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   state_t state;

   logic [SYNC_STAGES-1:0] sclk_sy;
   logic [SYNC_STAGES-1:0] ss_sy;
   logic [SYNC_STAGES-1:0] sdi_sy;
   logic sclk_q;
   logic ss_q;

   logic [2:0] bit_cnt;
   logic [7:0] rx;
   logic [7:0] tx;
   logic       rw;
   logic       mb;
   logic [5:0] addr;
   logic [9:0] x_sh;
   logic [9:0] y_sh;
   logic [9:0] z_sh;
   logic [7:0] bw_rate;
   logic       sdo_r;
   logic       sdo_en_r;

   logic sclk_s, ss_s, sdi_s;
   logic rise, fall, ss_fall, ss_rise;
   logic [7:0] rx_next;
   logic [5:0] addr_nx;
   logic       wr_ok;

   assign sclk_s  = sclk_sy[SYNC_STAGES-1];
   assign ss_s    = ss_sy[SYNC_STAGES-1];
   assign sdi_s   = sdi_sy[SYNC_STAGES-1];
   assign rise    = sclk_s & ~sclk_q;
   assign fall    = ~sclk_s & sclk_q;
   assign ss_fall = ~ss_s & ss_q;
   assign ss_rise = ss_s & ~ss_q;
   assign rx_next = {rx[6:0], sdi_s};
   assign addr_nx = mb ? addr + 6'd1 : addr;
   assign wr_ok   = (addr == 6'h2C) | (addr == 6'h2D) |
                    (addr == 6'h31);

   assign spi.SDO    = sdo_r;
   assign spi.SDO_EN = sdo_en_r;

   // Read mux; data bytes come from the frame-start snapshot.
   function automatic logic [7:0] reg_rd(input logic [5:0] a);
      logic [7:0] v;
      v = 8'h00;
      case (a)
         6'h00: v = DEVID_VAL;
         6'h2C: v = bw_rate;
         6'h2D: v = POWER_CTL;
         6'h31: v = DATA_FORMAT;
         6'h32: v = x_sh[7:0];
         6'h33: v = {{6{x_sh[9]}}, x_sh[9:8]};
         6'h34: v = y_sh[7:0];
         6'h35: v = {{6{y_sh[9]}}, y_sh[9:8]};
         6'h36: v = z_sh[7:0];
         6'h37: v = {{6{z_sh[9]}}, z_sh[9:8]};
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Idle levels preload the synchronizers so reset never
   // looks like an SCLK or SS edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sclk_sy <= '1;
         ss_sy   <= '1;
         sdi_sy  <= '0;
         sclk_q  <= 1'b1;
         ss_q    <= 1'b1;
      end else begin
         sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], spi.SCLK};
         ss_sy   <= {ss_sy[SYNC_STAGES-2:0], spi.SS};
         sdi_sy  <= {sdi_sy[SYNC_STAGES-2:0], spi.SDI};
         sclk_q  <= sclk_s;
         ss_q    <= ss_s;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         bit_cnt     <= 3'd0;
         rx          <= 8'h00;
         tx          <= 8'h00;
         rw          <= 1'b0;
         mb          <= 1'b0;
         addr        <= 6'h00;
         x_sh        <= 10'h000;
         y_sh        <= 10'h000;
         z_sh        <= 10'h000;
         bw_rate     <= 8'h0A;
         POWER_CTL   <= 8'h00;
         DATA_FORMAT <= 8'h00;
         WR_STROBE   <= 1'b0;
         WR_ADDR     <= 6'h00;
         WR_DATA     <= 8'h00;
         BUSY        <= 1'b0;
         sdo_r       <= 1'b0;
         sdo_en_r    <= 1'b0;
      end else begin
         WR_STROBE <= 1'b0;
         if (ss_rise) begin
            // Partial bytes are simply dropped here.
            state    <= IDLE;
            BUSY     <= 1'b0;
            sdo_en_r <= 1'b0;
            sdo_r    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_fall) begin
                     state    <= CMD;
                     x_sh     <= X_IN;
                     y_sh     <= Y_IN;
                     z_sh     <= Z_IN;
                     bit_cnt  <= 3'd0;
                     BUSY     <= 1'b1;
                     sdo_en_r <= 1'b1;
                  end
               end
               CMD: begin
                  if (rise) begin
                     rx      <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rw    <= rx_next[7];
                        mb    <= rx_next[6];
                        addr  <= rx_next[5:0];
                        state <= DATA;
                        if (rx_next[7])
                           tx <= reg_rd(rx_next[5:0]);
                     end
                  end
               end
               DATA: begin
                  if (rise) begin
                     rx      <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (!rw && wr_ok) begin
                           case (addr)
                              6'h2C:   bw_rate     <= rx_next;
                              6'h2D:   POWER_CTL   <= rx_next;
                              default: DATA_FORMAT <= rx_next;
                           endcase
                           WR_STROBE <= 1'b1;
                           WR_ADDR   <= addr;
                           WR_DATA   <= rx_next;
                        end
                        addr <= addr_nx;
                        if (rw)
                           tx <= reg_rd(addr_nx);
                     end
                  end else if (fall && rw) begin
                     sdo_r <= tx[7];
                     tx    <= {tx[6:0], 1'b0};
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
